alu_serial_driver: RTL and testbench
====================================

Name: alu_serial_driver

Overview:
- Bit-serial initiator for the one-bit ALU slice: latches WIDTH-bit operands and an operation code, then presents one operand bit pair per cycle to the slice, LSB first.
- Samples the slice's 6-bit per-operation output vector each cycle, reduces it to one result bit, and shifts that bit into a result register.
- Sits between the lab top-level (switches/controller) and a single combinational slice instance. This block is the driving/reading end of that slice interface.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; honoured only in IDLE.
- mode  input  1  operation mode; latched to the slice M input.
- sel  input  2  operation select; sel[0] drives slice S0, sel[1] drives slice S1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- slice_m  output  1  M to slice.
- slice_s0  output  1  S0 to slice.
- slice_s1  output  1  S1 to slice.
- slice_a  output  1  current A bit to slice.
- slice_b  output  1  current B bit to slice.
- slice_out  input  6  per-operation result vector from slice (combinational response to slice_* outputs).
- result  output  WIDTH  assembled result; valid when done=1 and held until the next accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result becomes valid.
- err  output  1  sticky error flag; cleared on accepted start.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. On rst: state=IDLE, result=0, busy=0, done=0, err=0, bit index=0, all slice_* outputs=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b, mode, sel into internal registers; clear index, result and err. Next state RUN, busy=1.
- IDLE, start=0: stay in IDLE; all outputs hold their values.
- RUN:
  - slice_a=a_reg[idx], slice_b=b_reg[idx], slice_m=mode_reg, slice_s0=sel_reg[0], slice_s1=sel_reg[1], all driven combinationally from registers.
  - Each edge: result[idx] <= OR-reduction of slice_out; idx <= idx+1.
  - When idx==WIDTH-1, next state is DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. result is stable from the DONE cycle onward.
- Latency: start sampled high at edge 0; RUN occupies edges 1..WIDTH; done is high in the cycle after edge WIDTH. Total: WIDTH+1 cycles from start to the done pulse.
- start asserted in RUN or DONE is ignored and not queued. Operand inputs may change freely after start is accepted.
- slice_* outputs are driven to 0 in IDLE and DONE.
- One-hot check: if more than one bit of slice_out is 1 on any RUN cycle, set err=1 (sticky until the next accepted start). The result bit is still the OR-reduction.
- Reset during RUN or DONE aborts the operation: no done pulse, and result returns to 0.
- Index counter width is clog2(WIDTH); it must not wrap before the DONE transition.

Optional Feature:
- Macro: ALU_SERIAL_SELFCHECK_EN.
- Defined: the block computes an expected bit each RUN cycle from the latched operation:
  - sel=00: A
  - sel=01: ~A
  - mode=0, sel=10: A^B
  - mode=0, sel=11: ~(A^B)
  - mode=1, sel=10: A|B
  - mode=1, sel=11: ~A|B
  - Any mismatch with the OR-reduction of slice_out sets err (sticky, same clearing rule as the one-hot check).
- Not defined: only the one-hot check drives err; no expected-value logic is synthesized.

Test Plan:
- WIDTH=8, a=0xA5, b=0x3C, mode=0, sel=10, start for one cycle -> busy for 8 cycles, done pulse 9 cycles after start, result=0x99, err=0.
- Same operands, mode=1, sel=10 -> result=0xBD; mode=1, sel=11 -> result=0x7E; mode=0, sel=11 -> result=0x66.
- sel=00 with mode=1 -> result=0xA5; sel=01 with mode=0 -> result=0x5A.
- start pulsed again at RUN cycle 3 with different operands -> ignored: exactly one done pulse, result from the original operands.
- rst asserted at RUN cycle 4 -> next cycle busy=0, result=0x00, no done pulse. A subsequent start completes normally.
- Slice model forced to return slice_out=6'b000011 on cycle 2 -> err=1 at done and remains 1 until the next start; with ALU_SERIAL_SELFCHECK_EN, a forced wrong result bit also sets err.

Source files
------------

// File: rtl/alu_serial_driver.sv
// Bit-serial initiator for a one-bit ALU slice: presents operand bits LSB first and assembles the result.
// Optional build macro ALU_SERIAL_SELFCHECK_EN adds an expected-bit compare that also feeds err.
module alu_serial_driver #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             slice_m,
   output logic             slice_s0,
   output logic             slice_s1,
   output logic             slice_a,
   output logic             slice_b,
   input  logic [5:0]       slice_out,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [WIDTH-1:0] a_reg, a_reg_nxt, b_reg, b_reg_nxt;
   logic             mode_reg, mode_reg_nxt;
   logic [1:0]       sel_reg, sel_reg_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic             busy_nxt, done_nxt, err_nxt;

   logic             run;
   logic             res_bit;
   logic             multi_hot;
   logic             bit_bad;

   // Slice drive is gated so the slice sees all zeros outside RUN.
   always_comb begin
      run      = (state == ST_RUN);
      slice_a  = run & a_reg[idx];
      slice_b  = run & b_reg[idx];
      slice_m  = run & mode_reg;
      slice_s0 = run & sel_reg[0];
      slice_s1 = run & sel_reg[1];
   end

   always_comb begin
      res_bit   = |slice_out;
      multi_hot = ((slice_out & (slice_out - 6'd1)) != 6'd0);
   end

`ifdef ALU_SERIAL_SELFCHECK_EN
   logic exp_bit;

   // Expected result bit for the latched operation on the current operand bits.
   always_comb begin
      exp_bit = 1'b0;
      case (sel_reg)
         2'b00: exp_bit = slice_a;
         2'b01: exp_bit = ~slice_a;
         2'b10: exp_bit = mode_reg ? (slice_a | slice_b) : (slice_a ^ slice_b);
         2'b11: exp_bit = mode_reg ? (~slice_a | slice_b) : ~(slice_a ^ slice_b);
         default: exp_bit = 1'b0;
      endcase
      bit_bad = multi_hot | (exp_bit != res_bit);
   end
`else
   always_comb bit_bad = multi_hot;
`endif

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      a_reg_nxt    = a_reg;
      b_reg_nxt    = b_reg;
      mode_reg_nxt = mode_reg;
      sel_reg_nxt  = sel_reg;
      result_nxt   = result;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      err_nxt      = err;
      case (state)
         ST_IDLE: begin
            if (start) begin
               a_reg_nxt    = a;
               b_reg_nxt    = b;
               mode_reg_nxt = mode;
               sel_reg_nxt  = sel;
               idx_nxt      = '0;
               result_nxt   = '0;
               err_nxt      = 1'b0;
               busy_nxt     = 1'b1;
               state_nxt    = ST_RUN;
            end
         end
         ST_RUN: begin
            result_nxt[idx] = res_bit;
            idx_nxt         = idx + IDX_W'(1);
            if (bit_bad) begin
               err_nxt = 1'b1;
            end
            // Leave on the last bit so idx never wraps inside RUN.
            if (idx == IDX_LAST) begin
               idx_nxt   = '0;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         mode_reg <= 1'b0;
         sel_reg  <= 2'b00;
         result   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         a_reg    <= a_reg_nxt;
         b_reg    <= b_reg_nxt;
         mode_reg <= mode_reg_nxt;
         sel_reg  <= sel_reg_nxt;
         result   <= result_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
      end
   end

endmodule

// File: tb/tb_alu_serial_driver.sv
// Bench for alu_serial_driver: slice model, table vectors, corner sequences and random ops vs word-level reference.
module tb_alu_serial_driver;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst, start, mode;
   logic [1:0]   sel;
   logic [W-1:0] a, b;
   logic         slice_m, slice_s0, slice_s1, slice_a, slice_b;
   logic [5:0]   slice_out, model_out;
   logic [W-1:0] result;
   logic         busy, done, err;
   logic         force_on;
   logic [5:0]   force_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_serial_driver #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel), .a(a), .b(b),
      .slice_m(slice_m), .slice_s0(slice_s0), .slice_s1(slice_s1),
      .slice_a(slice_a), .slice_b(slice_b), .slice_out(slice_out),
      .result(result), .busy(busy), .done(done), .err(err)
   );

   // One-bit slice: each operation owns one bit of the output vector.
   always_comb begin
      model_out = 6'b000000;
      case ({slice_m, slice_s1, slice_s0})
         3'b000, 3'b100: model_out[0] = slice_a;
         3'b001, 3'b101: model_out[1] = ~slice_a;
         3'b010:         model_out[2] = slice_a ^ slice_b;
         3'b011:         model_out[3] = ~(slice_a ^ slice_b);
         3'b110:         model_out[4] = slice_a | slice_b;
         3'b111:         model_out[5] = ~slice_a | slice_b;
         default:        model_out = 6'b000000;
      endcase
   end
   assign slice_out = force_on ? force_val : model_out;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         mode;
      logic [1:0]   sel;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [W-1:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                               input logic rm, input logic [1:0] rs);
      case (rs)
         2'b00:   return ra;
         2'b01:   return ~ra;
         2'b10:   return rm ? (ra | rb) : (ra ^ rb);
         default: return rm ? (~ra | rb) : ~(ra ^ rb);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation; outputs describe what was observed around it.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                         input logic [1:0] ts, input int force_cyc, input logic [5:0] fval,
                         input int restart_cyc,
                         output logic [W-1:0] res, output logic e_start, output logic e_done,
                         output logic e_end, output int lat, output int busy_n,
                         output int done_n, output logic drive_ok);
      a = ta; b = tb_v; mode = tm; sel = ts; start = 1'b1;
      step();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      e_start = err;
      lat = -1; busy_n = 0; done_n = 0; drive_ok = 1'b1;
      res = '0; e_done = 1'b0;
      for (int i = 0; i < 4 * int'(W); i++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (lat < 0) begin
               lat = i;
               res = result;
               e_done = err;
            end
         end
         if (i < int'(W)) begin
            if (slice_a !== ta[i] || slice_b !== tb_v[i] || slice_m !== tm ||
                {slice_s1, slice_s0} !== ts) drive_ok = 1'b0;
         end else if ({slice_m, slice_s1, slice_s0, slice_a, slice_b} !== 5'b0) begin
            drive_ok = 1'b0;
         end
         force_on  = (i == force_cyc);
         force_val = fval;
         if (i == restart_cyc) begin
            start = 1'b1; a = ~ta; b = ~tb_v; mode = ~tm; sel = ~ts;
         end else begin
            start = 1'b0;
         end
         step();
      end
      force_on = 1'b0;
      start = 1'b0;
      e_end = err;
   endtask

   logic [W-1:0] res;
   logic         e_start, e_done, e_end, drive_ok;
   int           lat, busy_n, done_n;
   logic [W-1:0] ra, rb;
   logic         rm;
   logic [1:0]   rs;

   initial begin
      vecs[0] = '{8'hA5, 8'h3C, 1'b0, 2'b10, 8'h99};
      vecs[1] = '{8'hA5, 8'h3C, 1'b1, 2'b10, 8'hBD};
      vecs[2] = '{8'hA5, 8'h3C, 1'b1, 2'b11, 8'h7E};
      vecs[3] = '{8'hA5, 8'h3C, 1'b0, 2'b11, 8'h66};
      vecs[4] = '{8'hA5, 8'h3C, 1'b1, 2'b00, 8'hA5};
      vecs[5] = '{8'hA5, 8'h3C, 1'b0, 2'b01, 8'h5A};

      rst = 1'b1; start = 1'b0; mode = 1'b0; sel = 2'b00; a = '0; b = '0;
      force_on = 1'b0; force_val = 6'b0;
      step(); step();
      chk("reset_result", 32'(result), 32'h0);
      chk("reset_flags", {29'b0, busy, done, err}, 32'h0);
      chk("reset_slice", {27'b0, slice_m, slice_s1, slice_s0, slice_a, slice_b}, 32'h0);
      rst = 1'b0;
      step();

      foreach (vecs[k]) begin
         run_op(vecs[k].a, vecs[k].b, vecs[k].mode, vecs[k].sel, -1, 6'b0, -1,
                res, e_start, e_done, e_end, lat, busy_n, done_n, drive_ok);
         chk($sformatf("vec%0d_result", k), 32'(res), 32'(vecs[k].exp));
         chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(W));
         chk($sformatf("vec%0d_busy_cycles", k), 32'(busy_n), 32'(W));
         chk($sformatf("vec%0d_done_pulses", k), 32'(done_n), 32'd1);
         chk($sformatf("vec%0d_err", k), {31'b0, e_done}, 32'h0);
         chk($sformatf("vec%0d_slice_drive", k), {31'b0, drive_ok}, 32'h1);
         chk($sformatf("vec%0d_result_held", k), 32'(result), 32'(vecs[k].exp));
      end

      // Start during RUN must be ignored.
      run_op(8'hA5, 8'h3C, 1'b0, 2'b10, -1, 6'b0, 3,
             res, e_start, e_done, e_end, lat, busy_n, done_n, drive_ok);
      chk("restart_result", 32'(res), 32'h99);
      chk("restart_done_pulses", 32'(done_n), 32'd1);
      chk("restart_busy_cycles", 32'(busy_n), 32'(W));

      // Multi-hot slice output on RUN cycle 2: bit 2 becomes 1, err sticky.
      run_op(8'hA5, 8'h3C, 1'b0, 2'b10, 2, 6'b000011, -1,
             res, e_start, e_done, e_end, lat, busy_n, done_n, drive_ok);
      chk("multihot_result", 32'(res), 32'h9D);
      chk("multihot_err_done", {31'b0, e_done}, 32'h1);
      chk("multihot_err_sticky", {31'b0, e_end}, 32'h1);
      run_op(8'h0F, 8'hF0, 1'b1, 2'b10, -1, 6'b0, -1,
             res, e_start, e_done, e_end, lat, busy_n, done_n, drive_ok);
      chk("err_cleared_on_start", {31'b0, e_start}, 32'h0);
      chk("after_err_result", 32'(res), 32'hFF);
      chk("after_err_err", {31'b0, e_done}, 32'h0);

      // One-hot but wrong bit: only the self-check flags it.
      run_op(8'hA5, 8'h3C, 1'b0, 2'b10, 2, 6'b000100, -1,
             res, e_start, e_done, e_end, lat, busy_n, done_n, drive_ok);
      chk("wrongbit_result", 32'(res), 32'h9D);
`ifdef ALU_SERIAL_SELFCHECK_EN
      chk("wrongbit_err", {31'b0, e_done}, 32'h1);
`else
      chk("wrongbit_err", {31'b0, e_done}, 32'h0);
`endif

      // Reset in the middle of RUN aborts without a done pulse.
      a = 8'hA5; b = 8'h3C; mode = 1'b0; sel = 2'b10; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("abort_busy_before", {31'b0, busy}, 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_result", 32'(result), 32'h0);
      done_n = 0;
      for (int i = 0; i < 3 * int'(W); i++) begin
         if (done) done_n++;
         step();
      end
      chk("abort_no_done", 32'(done_n), 32'd0);
      run_op(8'hA5, 8'h3C, 1'b1, 2'b11, -1, 6'b0, -1,
             res, e_start, e_done, e_end, lat, busy_n, done_n, drive_ok);
      chk("post_abort_result", 32'(res), 32'h7E);
      chk("post_abort_latency", 32'(lat), 32'(W));

      // Random operations against the word-level reference.
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom); rb = W'($urandom);
         rm = 1'($urandom); rs = 2'($urandom);
         run_op(ra, rb, rm, rs, -1, 6'b0, -1,
                res, e_start, e_done, e_end, lat, busy_n, done_n, drive_ok);
         chk($sformatf("rand%0d_result", n), 32'(res), 32'(ref_result(ra, rb, rm, rs)));
         chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(W));
         chk($sformatf("rand%0d_err", n), {31'b0, e_done}, 32'h0);
         chk($sformatf("rand%0d_drive", n), {31'b0, drive_ok}, 32'h1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
